// File: rtl/instr_mem_loader.sv
// Instruction-memory loader.
// Takes a byte stream over a valid/ready handshake and turns it into 16-bit instruction-memory
// writes. The stream starts with a big-endian 16-bit word count N, followed by N big-endian
// instruction words. Word i is written to BASE_ADDR + 2*i. While a load is in progress, or after
// an abort, the CPU is held. The hold is released once the load completes.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   When defined, one trailing byte follows the last word. It must equal the XOR of every earlier
//   byte of the load, count bytes included. A mismatch ends in the error state. Memory has
//   already been written by then.
//   When undefined, the load is done right after the last write, and no trailing byte is read.
module instr_mem_loader #(
  parameter int unsigned       ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       MAX_WORDS = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_byte_in,
  input  logic              i_byte_valid,
  output logic              o_byte_ready,
  output logic              o_im_we,
  output logic [ADDR_W-1:0] o_im_addr,
  output logic [15:0]       o_im_wdata,
  output logic              o_cpu_hold,
  output logic              o_done,
  output logic              o_error
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CNT_HI = 4'd1;
  localparam logic [3:0] S_CNT_LO = 4'd2;
  localparam logic [3:0] S_W_HI   = 4'd3;
  localparam logic [3:0] S_W_LO   = 4'd4;
  localparam logic [3:0] S_WRITE  = 4'd5;
  localparam logic [3:0] S_DONE   = 4'd6;
  localparam logic [3:0] S_ERR    = 4'd7;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [3:0] S_CHK    = 4'd8;
`endif

  logic [3:0]        r_state;
  logic [3:0]        w_state_nxt;
  logic [7:0]        r_cnt_hi;
  logic [7:0]        w_cnt_hi_nxt;
  logic [15:0]       r_n;
  logic [15:0]       w_n_nxt;
  logic [15:0]       r_count;
  logic [15:0]       w_count_nxt;
  logic [7:0]        r_hi;
  logic [7:0]        w_hi_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [15:0]       r_wdata;
  logic [15:0]       w_wdata_nxt;

  logic              w_xfer;
  logic              w_restart;
  logic [15:0]       w_n_rx;
  logic [15:0]       w_count_inc;
  logic              w_last;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
  logic [7:0]        w_csum_nxt;
`endif

  // Handshake and small shared decodes.
  always_comb begin
    w_xfer      = i_byte_valid & o_byte_ready;
    w_restart   = i_start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    w_n_rx      = {r_cnt_hi, i_byte_in};
    w_count_inc = r_count + 16'd1;
    w_last      = (w_count_inc == r_n);
  end

  // Ready is a pure state decode, so nothing combinational runs from valid to ready.
  always_comb begin
    o_byte_ready = 1'b0;
    case (r_state)
      S_CNT_HI, S_CNT_LO, S_W_HI, S_W_LO: o_byte_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
      S_CHK:                              o_byte_ready = 1'b1;
`endif
      default:                            o_byte_ready = 1'b0;
    endcase
  end

  // Status outputs and the memory write port, all decoded from registered state.
  always_comb begin
    o_im_we    = (r_state == S_WRITE);
    o_im_addr  = r_addr;
    o_im_wdata = r_wdata;
    o_cpu_hold = (r_state != S_DONE);
    o_done     = (r_state == S_DONE);
    o_error    = (r_state == S_ERR);
  end

  // Next-state logic for the load sequencer and its datapath registers.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_hi_nxt = r_cnt_hi;
    w_n_nxt      = r_n;
    w_count_nxt  = r_count;
    w_hi_nxt     = r_hi;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (w_restart) begin
          w_state_nxt = S_CNT_HI;
          w_addr_nxt  = BASE_ADDR;
          w_count_nxt = 16'd0;
        end
      end
      S_CNT_HI: begin
        if (w_xfer) begin
          w_cnt_hi_nxt = i_byte_in;
          w_state_nxt  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (w_xfer) begin
          w_n_nxt = w_n_rx;
          if (w_n_rx == 16'd0) begin
            w_state_nxt = S_DONE;
          end else if (32'(w_n_rx) > MAX_WORDS) begin
            w_state_nxt = S_ERR;
          end else begin
            w_state_nxt = S_W_HI;
          end
        end
      end
      S_W_HI: begin
        if (w_xfer) begin
          w_hi_nxt    = i_byte_in;
          w_state_nxt = S_W_LO;
        end
      end
      S_W_LO: begin
        if (w_xfer) begin
          w_wdata_nxt = {r_hi, i_byte_in};
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // The address advances only after the write cycle, so the address is stable while
        // the strobe is high. It wraps naturally at 2^ADDR_W.
        w_addr_nxt  = r_addr + ADDR_W'(2);
        w_count_nxt = w_count_inc;
        if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
          w_state_nxt = S_CHK;
`else
          w_state_nxt = S_DONE;
`endif
        end else begin
          w_state_nxt = S_W_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        if (w_xfer) begin
          w_state_nxt = (i_byte_in == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of the count and data bytes. The check byte itself is not folded in.
  always_comb begin
    w_csum_nxt = r_csum;
    if (w_restart) begin
      w_csum_nxt = 8'h00;
    end else if (w_xfer && (r_state != S_CHK)) begin
      w_csum_nxt = r_csum ^ i_byte_in;
    end
  end

  // Checksum accumulator register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_csum <= 8'h00;
    end else begin
      r_csum <= w_csum_nxt;
    end
  end
`endif

  // State and datapath registers. Reset drops any partial load at once.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= S_IDLE;
      r_cnt_hi <= 8'h00;
      r_n      <= 16'd0;
      r_count  <= 16'd0;
      r_hi     <= 8'h00;
      r_addr   <= BASE_ADDR;
      r_wdata  <= 16'h0000;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt_hi <= w_cnt_hi_nxt;
      r_n      <= w_n_nxt;
      r_count  <= w_count_nxt;
      r_hi     <= w_hi_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
    end
  end

endmodule
